// File: rtl/demo_out_monitor.sv
// Change-capture monitor: timestamps each new value of in_value and queues it in a small FIFO.
// Optional macro DEMO_MON_OVERWRITE_EN: when full, overwrite the newest entry instead of dropping.
module demo_out_monitor #(
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               in_value,
  input  logic                      enable,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_value,
  output logic [TS_WIDTH-1:0]       out_stamp,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 32 + TS_WIDTH;

  localparam logic ST_INITIAL = 1'b0;
  localparam logic ST_RUN     = 1'b1;

  localparam logic [PTR_W-1:0]    PTR_ONE   = 1;
  localparam logic [PTR_W:0]      COUNT_ONE = 1;
  localparam logic [PTR_W:0]      COUNT_MAX = DEPTH;
  localparam logic [TS_WIDTH-1:0] TS_ONE    = 1;

  logic                 state_reg;
  logic [31:0]          last_reg;
  logic [TS_WIDTH-1:0]  ts_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [PTR_W:0]       count_reg;
  logic                 overflow_reg;
  logic [ENTRY_W-1:0]   head_reg;
  logic [ENTRY_W-1:0]   mem [DEPTH];

  logic                 change;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic                 drop;
  logic                 mem_we;
  logic [PTR_W-1:0]     mem_addr;
  logic [PTR_W-1:0]     rd_next;
  logic [PTR_W-1:0]     rd_addr;
  logic [ENTRY_W-1:0]   wr_data;

  assign change  = !reset && (state_reg == ST_RUN) && enable && (in_value != last_reg);
  assign pop     = (count_reg != '0) && out_ready;
  assign full    = (count_reg == COUNT_MAX);
  assign push_ok = change && (!full || pop);
  assign drop    = change && full && !pop;
  assign wr_data = {in_value, ts_reg};
  assign rd_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
  assign rd_addr = reset ? '0 : rd_next;

`ifdef DEMO_MON_OVERWRITE_EN
  // A full FIFO with DEPTH >= 2 never has its head at wr_ptr-1, so the head is untouched.
  assign mem_we   = push_ok || drop;
  assign mem_addr = drop ? wr_ptr_reg - PTR_ONE : wr_ptr_reg;
`else
  assign mem_we   = push_ok;
  assign mem_addr = wr_ptr_reg;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= wr_data;
    end
  end

  // Registered head read; bypass covers an entry written into the slot being read this edge.
  always_ff @(posedge clk) begin
    if (mem_we && (mem_addr == rd_addr)) begin
      head_reg <= wr_data;
    end else begin
      head_reg <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_INITIAL;
      ts_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INITIAL: begin
          last_reg  <= in_value;
          ts_reg    <= '0;
          state_reg <= ST_RUN;
        end
        default: begin
          if (enable) begin
            ts_reg <= ts_reg + TS_ONE;
          end
          if (change) begin
            last_reg <= in_value;
          end
        end
      endcase
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (push_ok && !pop) begin
        count_reg <= count_reg + COUNT_ONE;
      end else if (pop && !push_ok) begin
        count_reg <= count_reg - COUNT_ONE;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign out_valid = (count_reg != '0);
  assign out_value = head_reg[ENTRY_W-1:TS_WIDTH];
  assign out_stamp = head_reg[TS_WIDTH-1:0];
  assign count     = count_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_demo_out_monitor.sv
// Bench for demo_out_monitor: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based model of the monitor.
module tb_demo_out_monitor;

  localparam int DEPTH    = 4;
  localparam int TS_WIDTH = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [31:0]         in_value;
  logic                enable;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_value;
  logic [TS_WIDTH-1:0] out_stamp;
  logic [CW-1:0]       count;
  logic                overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demo_out_monitor #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
    .clk(clk), .reset(reset), .in_value(in_value), .enable(enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_stamp(out_stamp), .count(count), .overflow(overflow)
  );

  // Reference model: a queue of (value, stamp) pairs plus the sampling state.
  logic [31:0] q_val[$];
  int          q_stamp[$];
  logic [31:0] m_last;
  int          m_ts;
  bit          m_init;
  bit          m_ovf;
  bit          model_live = 1'b0;
  bit          m_pop;
  bit          m_push;
  int          m_size;

  always @(posedge clk) begin
    if (reset) begin
      q_val.delete();
      q_stamp.delete();
      m_ovf      = 1'b0;
      m_ts       = 0;
      m_init     = 1'b1;
      model_live = 1'b1;
    end else if (m_init) begin
      m_last = in_value;
      m_ts   = 0;
      m_init = 1'b0;
    end else begin
      m_size = q_val.size();
      m_pop  = (m_size > 0) && out_ready;
      m_push = enable && (in_value != m_last);
      if (m_pop) begin
        void'(q_val.pop_front());
        void'(q_stamp.pop_front());
      end
      if (m_push) begin
        if (m_size < DEPTH || m_pop) begin
          q_val.push_back(in_value);
          q_stamp.push_back(m_ts);
        end else begin
          m_ovf = 1'b1;
`ifdef DEMO_MON_OVERWRITE_EN
          q_val[q_val.size()-1]     = in_value;
          q_stamp[q_stamp.size()-1] = m_ts;
`endif
        end
        m_last = in_value;
      end
      if (enable) m_ts = (m_ts + 1) % (1 << TS_WIDTH);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      check("model_count", 32'(count), 32'(q_val.size()));
      check("model_valid", 32'(out_valid), 32'(q_val.size() != 0));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
      if (q_val.size() != 0) begin
        check("model_value", out_value, q_val[0]);
        check("model_stamp", 32'(out_stamp), 32'(q_stamp[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] drain_exp [4];
  int          thresh;

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; in_value = 32'd0;
    step(); step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    $display("reset: count=%0d valid=%0b overflow=%0b", count, out_valid, overflow);

    // Basic capture: change arrives at the compare with ts=3.
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    repeat (4) step();
    in_value = 32'd5;
    step();
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_value", out_value, 32'd5);
    check("basic_stamp", 32'(out_stamp), 32'd3);
    $display("basic: value=%0d stamp=%0d count=%0d", out_value, out_stamp, count);
    step();
    check("basic_drained", 32'(count), 32'd0);

    // Demo stream 0,1,0,1: consecutive stamps 5..8.
    for (int i = 0; i < 4; i++) begin
      in_value = 32'(i % 2);
      step();
      check("stream_value", out_value, 32'(i % 2));
      check("stream_stamp", 32'(out_stamp), 32'((5 + i) % 16));
      check("stream_count", 32'(count), 32'd1);
      $display("stream: value=%0d stamp=%0d", out_value, out_stamp);
    end
    check("stream_overflow", 32'(overflow), 32'd0);

    // Fill and overflow with values 1..5.
    in_value = 32'd0;
    step(); step();
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      in_value = 32'(v);
      step();
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_overflow", 32'(overflow), 32'd1);
    $display("fill: count=%0d overflow=%0b", count, overflow);
    drain_exp[0] = 32'd1; drain_exp[1] = 32'd2; drain_exp[2] = 32'd3;
`ifdef DEMO_MON_OVERWRITE_EN
    drain_exp[3] = 32'd5;
`else
    drain_exp[3] = 32'd4;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_value", out_value, drain_exp[i]);
      $display("drain: value=%0d stamp=%0d", out_value, out_stamp);
      step();
    end
    check("drain_empty", 32'(count), 32'd0);

    // Full with simultaneous push and pop.
    reset = 1'b1; step();
    reset = 1'b0; step();
    out_ready = 1'b0;
    for (int v = 11; v <= 14; v++) begin
      in_value = 32'(v);
      step();
    end
    check("full_count", 32'(count), 32'd4);
    out_ready = 1'b1; in_value = 32'd15;
    step();
    check("pushpop_count", 32'(count), 32'd4);
    check("pushpop_head", out_value, 32'd12);
    check("pushpop_overflow", 32'(overflow), 32'd0);
    $display("pushpop: head=%0d count=%0d overflow=%0b", out_value, count, overflow);
    repeat (4) step();
    check("pushpop_drained", 32'(count), 32'd0);

    // Enable gating: ts frozen at 9.
    enable = 1'b0; in_value = 32'd7;
    step();
    in_value = 32'd9;
    step(); step();
    check("gate_count", 32'(count), 32'd0);
    enable = 1'b1;
    step();
    check("gate_count_on", 32'(count), 32'd1);
    check("gate_value", out_value, 32'd9);
    check("gate_stamp", 32'(out_stamp), 32'd9);
    $display("gate: value=%0d stamp=%0d", out_value, out_stamp);
    step();

    // Mid-operation reset with three entries queued.
    out_ready = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      in_value = 32'(v);
      step();
    end
    check("midrst_pre_count", 32'(count), 32'd3);
    reset = 1'b1;
    step();
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    $display("midreset: count=%0d valid=%0b overflow=%0b", count, out_valid, overflow);

    // Timestamp wrap: 17th compare is stamped 0.
    in_value = 32'd0; reset = 1'b0;
    step();
    repeat (16) step();
    in_value = 32'd3;
    step();
    check("wrap_value", out_value, 32'd3);
    check("wrap_stamp", 32'(out_stamp), 32'd0);
    $display("wrap: value=%0d stamp=%0d", out_value, out_stamp);

    // Randomized traffic, alternating consumer pressure to reach full and empty.
    thresh = 8;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) thresh = (thresh == 8) ? 2 : 8;
      reset     = ($urandom_range(0, 149) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < thresh);
      in_value  = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 3));
      step();
    end
    $display("random: done, count=%0d overflow=%0b", count, overflow);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
